// File: rtl/fc_stream_host.sv
// Host-side streaming driver for a fully connected layer: sends N words
// from an input buffer, then collects M result words into a result buffer.
module fc_stream_host #(
  parameter int M = 8,
  parameter int N = 10,
  parameter int T = 16,
  localparam int NW = (N > 1) ? $clog2(N) : 1,
  localparam int MW = (M > 1) ? $clog2(M) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          host_wr_en,
  input  logic [NW-1:0] host_wr_addr,
  input  logic [T-1:0]  host_wr_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          s_valid,
  input  logic          s_ready,
  output logic [T-1:0]  s_data,
  input  logic          r_valid,
  output logic          r_ready,
  input  logic [T-1:0]  r_data,
  input  logic [MW-1:0] res_addr,
  output logic [T-1:0]  res_data
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    RECV,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [T-1:0] xbuf [N];
  logic [T-1:0] ybuf [M];

  logic [NW-1:0] sidx;
  logic [MW-1:0] ridx;

  logic s_hs, r_hs;
  logic s_last, r_last;
  logic wr_ok;

  // Handshake outputs decode straight from the state register so they
  // drop together with the asynchronous reset.
  assign s_valid = (state == SEND);
  assign r_ready = (state == RECV);
  assign busy    = s_valid | r_ready;
  assign done    = (state == DONE);
  assign s_data  = xbuf[sidx];

  assign s_hs   = s_valid & s_ready;
  assign r_hs   = r_valid & r_ready;
  assign s_last = (sidx == NW'(N - 1));
  assign r_last = (ridx == MW'(M - 1));

  assign wr_ok = host_wr_en
               & ((state == IDLE) | (state == DONE))
               & (32'(host_wr_addr) < N);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = SEND;
      SEND: if (s_hs && s_last) state_nx = RECV;
      RECV: if (r_hs && r_last) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sidx  <= '0;
      ridx  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        sidx <= '0;
        ridx <= '0;
      end else begin
        if (s_hs && !s_last) sidx <= sidx + NW'(1);
        if (r_hs && !r_last) ridx <= ridx + MW'(1);
      end
    end
  end

  // Buffer contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_ok) xbuf[host_wr_addr] <= host_wr_data;
    if (r_hs) ybuf[ridx] <= r_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_data <= '0;
    end else if (32'(res_addr) < M) begin
      res_data <= ybuf[res_addr];
    end else begin
      res_data <= '0;
    end
  end

endmodule

// File: tb/tb_fc_stream_host.sv
// Directed bench for fc_stream_host: send/receive sequencing, stalls,
// ignored inputs, mid-transaction reset and back-to-back starts.
module tb_fc_stream_host;

  localparam int M = 8;
  localparam int N = 10;
  localparam int T = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         host_wr_en;
  logic [3:0]   host_wr_addr;
  logic [T-1:0] host_wr_data;
  logic         start;
  logic         busy;
  logic         done;
  logic         s_valid;
  logic         s_ready;
  logic [T-1:0] s_data;
  logic         r_valid;
  logic         r_ready;
  logic [T-1:0] r_data;
  logic [2:0]   res_addr;
  logic [T-1:0] res_data;

  int n_chk = 0;
  int n_fail = 0;
  int e;

  logic [T-1:0] rv [8] = '{16'hFFFB, 16'd7, 16'd0, 16'h7FFF,
                           16'h8000, 16'd1, 16'd2, 16'd3};
  int gap [8] = '{0, 1, 0, 2, 0, 0, 1, 0};

  fc_stream_host #(.M(M), .N(N), .T(T)) dut (
    .clk          (clk),
    .reset        (reset),
    .host_wr_en   (host_wr_en),
    .host_wr_addr (host_wr_addr),
    .host_wr_data (host_wr_data),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .r_valid      (r_valid),
    .r_ready      (r_ready),
    .r_data       (r_data),
    .res_addr     (res_addr),
    .res_data     (res_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    host_wr_en = 1'b0;
    host_wr_addr = '0;
    host_wr_data = '0;
    start = 1'b0;
    s_ready = 1'b0;
    r_valid = 1'b0;
    r_data = '0;
    res_addr = '0;

    step();
    step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_svalid", 32'(s_valid), 0);
    chk("rst_rready", 32'(r_ready), 0);
    chk("rst_resdata", 32'(res_data), 0);
    reset = 1'b1;
    step();

    for (int i = 0; i < N; i++) begin
      host_wr_en = 1'b1;
      host_wr_addr = 4'(i);
      host_wr_data = 16'(i + 1);
      step();
    end
    host_wr_addr = 4'd12;
    host_wr_data = 16'hDEAD;
    step();
    host_wr_en = 1'b0;

    // Transaction 1: s_ready held high, gapped receive.
    s_ready = 1'b1;
    start = 1'b1;
    chk("t1_svalid_pre", 32'(s_valid), 0);
    step();
    start = 1'b0;
    for (int k = 0; k < N; k++) begin
      chk("t1_svalid", 32'(s_valid), 1);
      chk("t1_sdata", 32'(s_data), 32'(k + 1));
      step();
    end
    chk("t1_svalid_end", 32'(s_valid), 0);
    chk("t1_rready", 32'(r_ready), 1);
    for (int k = 0; k < M; k++) begin
      for (int g = 0; g < gap[k]; g++) begin
        r_valid = 1'b0;
        step();
        chk("t1_done_gap", 32'(done), 0);
      end
      r_valid = 1'b1;
      r_data = rv[k];
      step();
    end
    r_valid = 1'b0;
    chk("t1_done", 32'(done), 1);
    chk("t1_busy_done", 32'(busy), 0);
    chk("t1_rready_done", 32'(r_ready), 0);
    step();
    chk("t1_done_pulse", 32'(done), 0);
    for (int a = 0; a < M; a++) begin
      res_addr = 3'(a);
      step();
      chk("t1_readback", 32'(res_data), 32'(rv[a]));
    end

    // Transaction 2: stalled send, r_valid noise during SEND.
    res_addr = 3'd0;
    r_valid = 1'b1;
    r_data = 16'h1234;
    start = 1'b1;
    step();
    start = 1'b0;
    e = 0;
    for (int c = 0; c < 60 && e < N; c++) begin
      chk("t2_svalid", 32'(s_valid), 1);
      chk("t2_sdata", 32'(s_data), 32'(e + 1));
      chk("t2_nostore", 32'(res_data), 32'hFFFB);
      s_ready = (c % 3 == 0);
      step();
      if (s_ready) e++;
      if (e == N) r_valid = 1'b0;
    end
    chk("t2_send_count", 32'(e), 32'(N));
    chk("t2_rready", 32'(r_ready), 1);
    chk("t2_nostore_end", 32'(res_data), 32'hFFFB);

    start = 1'b1;
    host_wr_en = 1'b1;
    host_wr_addr = 4'd0;
    host_wr_data = 16'h7777;
    s_ready = 1'b1;
    step();
    start = 1'b0;
    host_wr_en = 1'b0;
    chk("t2_norestart_busy", 32'(busy), 1);
    chk("t2_norestart_svalid", 32'(s_valid), 0);
    step();
    chk("t2_still_recv", 32'(r_ready), 1);

    r_valid = 1'b1;
    for (int k = 0; k < M; k++) begin
      r_data = 16'(100 + k);
      step();
      if (k == 0) chk("t2_read_old", 32'(res_data), 32'hFFFB);
      if (k == 1) chk("t2_read_new", 32'(res_data), 32'd100);
    end
    r_valid = 1'b0;
    chk("t2_done", 32'(done), 1);

    // Start in DONE is ignored; start the cycle after DONE is accepted.
    start = 1'b1;
    step();
    chk("t3_done_start_ign", 32'(busy), 0);
    chk("t3_idle_svalid", 32'(s_valid), 0);
    step();
    start = 1'b0;
    chk("t3_b2b_svalid", 32'(s_valid), 1);
    chk("t3_b2b_sdata", 32'(s_data), 1);
    repeat (4) step();
    chk("t3_sdata_4", 32'(s_data), 5);
    reset = 1'b0;
    #1;
    chk("t3_rst_svalid", 32'(s_valid), 0);
    chk("t3_rst_busy", 32'(busy), 0);
    chk("t3_rst_rready", 32'(r_ready), 0);
    chk("t3_rst_done", 32'(done), 0);
    chk("t3_rst_resdata", 32'(res_data), 0);
    @(negedge clk);
    reset = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < N; k++) begin
      chk("t3_resend", 32'(s_data), 32'(k + 1));
      step();
    end
    chk("t3_rready", 32'(r_ready), 1);
    r_valid = 1'b1;
    for (int k = 0; k < M; k++) begin
      r_data = rv[k];
      step();
    end
    r_valid = 1'b0;
    chk("t3_done", 32'(done), 1);
    res_addr = 3'd3;
    step();
    chk("t3_readback", 32'(res_data), 32'h7FFF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fc_stream_host.md
FC_STREAM_HOST -- requirements
Module: fc_stream_host

Interface
REQ-001 Parameter M, default 8: number of result words received per transaction (layer output length).
REQ-002 Parameter N, default 10: number of input words sent per transaction (layer input length).
REQ-003 Parameter T, default 16: signed word width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately.
REQ-006 host_wr_en  input  1  writes host_wr_data into the input buffer at host_wr_addr.
REQ-007 host_wr_addr  input  $clog2(N)  input buffer write index, 0..N-1.
REQ-008 host_wr_data  input  T  signed input word.
REQ-009 start  input  1  single-cycle request to run one transaction.
REQ-010 busy  output  1  high in SEND and RECV.
REQ-011 done  output  1  one-cycle pulse when all M results are stored.
REQ-012 s_valid  output  1  send-side valid; drives the layer's input_valid.
REQ-013 s_ready  input  1  send-side ready; driven by the layer's input_ready.
REQ-014 s_data  output  T  send-side signed word; drives the layer's input_data.
REQ-015 r_valid  input  1  receive-side valid; driven by the layer's output_valid.
REQ-016 r_ready  output  1  receive-side ready; drives the layer's output_ready.
REQ-017 r_data  input  T  receive-side signed word from the layer's output_data.
REQ-018 res_addr  input  $clog2(M)  result buffer read index, 0..M-1.
REQ-019 res_data  output  T  result word at res_addr, registered, 1-cycle read latency.

Function
REQ-020 The block SHALL hold an N-entry input buffer xbuf, an M-entry result buffer ybuf, send index sidx, and receive index ridx.
REQ-021 FSM states SHALL be IDLE, SEND, RECV, DONE; transitions IDLE->SEND on start, SEND->RECV on the handshake with sidx==N-1, RECV->DONE on the handshake with ridx==M-1, DONE->IDLE unconditionally after 1 cycle.
REQ-022 On entering SEND, sidx and ridx SHALL be 0; s_valid SHALL rise the cycle after start is sampled.
REQ-023 In SEND: s_valid=1, s_data=xbuf[sidx]; a send handshake (s_valid&&s_ready) SHALL increment sidx by 1.
REQ-024 s_data SHALL remain stable while s_valid=1 and s_ready=0; s_valid SHALL NOT drop before its handshake.
REQ-025 In RECV: r_ready=1; a receive handshake (r_valid&&r_ready) SHALL write r_data into ybuf[ridx] and increment ridx by 1.
REQ-026 Outside RECV, r_ready SHALL be 0 and r_valid/r_data SHALL be ignored; outside SEND, s_valid SHALL be 0.
REQ-027 done SHALL be 1 only in DONE; busy SHALL be 1 only in SEND and RECV.
REQ-028 host_wr_en SHALL write xbuf only in IDLE or DONE; writes during SEND/RECV SHALL be dropped.
REQ-029 start SHALL be ignored in any state other than IDLE, including DONE.
REQ-030 Indices SHALL never wrap: sidx stays within 0..N-1, ridx within 0..M-1; the last handshake moves the FSM and does not increment.
REQ-031 Out-of-range host_wr_addr (>=N) SHALL be ignored; out-of-range res_addr SHALL return 0.
REQ-032 res_data SHALL be readable in any state; a read of the index being written in the same cycle SHALL return the old value.
REQ-033 Words SHALL pass through unmodified: no sign extension, saturation, or reordering.

Reset
REQ-034 When reset=0: state=IDLE, sidx=ridx=0, s_valid=0, r_ready=0, busy=0, done=0, res_data=0.
REQ-035 xbuf and ybuf contents SHALL NOT be cleared by reset.
REQ-036 Reset asserted mid-SEND or mid-RECV SHALL abort the transaction; s_valid and r_ready SHALL fall asynchronously with reset.

Verification
REQ-037 Load xbuf[i]=i+1 (i=0..9), pulse start, hold s_ready=1 -> s_data 1..10 on 10 consecutive cycles, starting 1 cycle after start, then r_ready=1.
REQ-038 In SEND, toggle s_ready 1,0,0,1,... -> each word is held while s_ready=0, exactly 10 handshakes occur, and no value is skipped or repeated.
REQ-039 In RECV, drive r_data=-5,7,0,32767,-32768,1,2,3 with random r_valid gaps -> done pulses once for 1 cycle; res_addr 0..7 read back the same values 1 cycle later.
REQ-040 Assert r_valid=1 during SEND, and pulse start and host_wr_en during RECV -> nothing is stored, no restart occurs, and xbuf is unchanged.
REQ-041 Drop reset to 0 after 4 send handshakes -> outputs are immediately at reset values; restarting sends from xbuf[0], and xbuf still holds 1..10.
REQ-042 Use back-to-back transactions with start in the cycle after done -> the second transaction starts normally, since the FSM is back in IDLE.
